// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package fetch_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction memory read port, redirect input and decode handshake.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Flushable FIFO of {pc, instr} fetch entries; flush overrides a same-cycle push.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fq_entry_t              wdata,
  output fq_entry_t              rdata,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  fq_entry_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign occupancy = wr_ptr - rd_ptr;
  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign empty     = (occupancy == '0);
  assign do_pop    = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign rdata     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues imem reads, queues responses for decode.
// Optional FETCH_PERF_CNT_EN adds fetch and bubble performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_cnt,
  output logic [XLEN-1:0] perf_bubble_cnt
`endif
);
  localparam int unsigned OW = $clog2(FQ_DEPTH) + 1;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, resp_pc;
  logic            inflight, issue, credit_ok;
  logic            pop, pop_eff, push;
  logic [OW-1:0]   occupancy;
  logic [OW:0]     demand;
  logic            fq_full, fq_empty;
  fq_entry_t       head, wr_entry;

  assign pop       = bus.if_valid & bus.id_ready;
  assign pop_eff   = pop & ~bus.redirect_valid;
  assign demand    = {1'b0, occupancy} + {{OW{1'b0}}, inflight} - {{OW{1'b0}}, pop};
  assign credit_ok = (demand < (OW+1)'(FQ_DEPTH));
  // A redirect kills the returning response; the flush also drops the queue.
  assign push      = inflight & ~bus.redirect_valid & (~fq_full | pop_eff);
  assign wr_entry  = '{pc: resp_pc, instr: bus.imem_rdata};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    issue     = 1'b0;
    if (bus.redirect_valid) begin
      state_nxt = S_RUN;
      pc_nxt    = align_pc(bus.redirect_pc);
    end else begin
      unique case (state)
        S_BOOT: state_nxt = S_RUN;
        S_RUN: begin
          if (credit_ok) begin
            issue  = 1'b1;
            pc_nxt = pc + PC_STEP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
        S_WAIT:  if (credit_ok) state_nxt = S_RUN;
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_BOOT;
      pc       <= align_pc(RESET_PC);
      inflight <= 1'b0;
      resp_pc  <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      inflight <= issue;
      if (issue) resp_pc <= pc;
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop_eff),
    .flush     (bus.redirect_valid),
    .wdata     (wr_entry),
    .rdata     (head),
    .occupancy (occupancy),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = issue ? pc : '0;
  assign bus.if_valid  = ~fq_empty;
  assign bus.if_instr  = fq_empty ? NOP_INSTR : head.instr;
  assign bus.if_pc     = fq_empty ? '0 : head.pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (pop_eff) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (fq_empty && state != S_BOOT) perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
    end
  end
`endif
endmodule
